// File: rtl/acc_bank_pkg.sv
// rtl/acc_bank_pkg.sv - shared encodings, FSM states and saturation helper for the accumulation bank
package acc_bank_pkg;

    localparam logic [1:0] OP_ACCUM = 2'b00;
    localparam logic [1:0] OP_FILL  = 2'b01;
    localparam logic [1:0] OP_DRAIN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    // Clamp a sign-extended sum into the signed range of a dw-bit word (dw <= 31).
    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v, input int dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/acc_bank_mem.sv
// rtl/acc_bank_mem.sv - simple dual-port DEPTH x DW RAM with one-cycle registered read
module acc_bank_mem #(
    parameter int DW    = 16,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Read-before-write on a same-address collision; the top forwards around it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/accum_bank_array_v2.sv
// rtl/accum_bank_array_v2.sv - banked accumulation store with bias fill, forwarded RMW and skid-buffered drain
module accum_bank_array_v2
    import acc_bank_pkg::*;
#(
    parameter int DW            = 16,
    parameter int NUM_BANKS     = 16,
    parameter int DEPTH         = 512,
    parameter int AW            = $clog2(DEPTH),
    parameter int BW            = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter bit SATURATE      = 1'b1,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    input  logic [1:0]                cmd_op,
    input  logic [AW:0]               cmd_len,
    output logic                      cmd_ready,
    input  logic [NUM_BANKS*DW-1:0]   bias_vec,
    input  logic                      partial_valid,
    input  logic signed [DW-1:0]      partial_data,
    input  logic [BW-1:0]             partial_bank,
    input  logic [AW-1:0]             partial_addr,
    input  logic                      accum_done,
    output logic [NUM_BANKS*DW-1:0]   m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic                      busy,
    output logic                      err_drop
);

    state_t                    state;
    logic [AW:0]               cnt;
    logic [AW:0]               len_q;
    logic [NUM_BANKS*DW-1:0]   bias_q;

    logic                      bank_bad, accept;
    logic                      s1_valid, s2_valid, s3_valid;
    logic [BW-1:0]             s1_bank, s2_bank, s3_bank;
    logic [AW-1:0]             s1_addr, s2_addr, s3_addr;
    logic signed [DW-1:0]      s1_data, s2_sum, s3_sum;
    logic signed [DW-1:0]      s1_old, s1_res;
    logic signed [DW:0]        sum_w;

    logic [NUM_BANKS-1:0]      mem_we;
    logic [AW-1:0]             mem_waddr [NUM_BANKS];
    logic [DW-1:0]             mem_wdata [NUM_BANKS];
    logic [DW-1:0]             rdata     [NUM_BANKS];
    logic                      mem_re;
    logic [AW-1:0]             mem_raddr;

    logic                      rd_issue, rd_inflight, rd_inflight_last, pop, push;
    logic [1:0]                fifo_cnt, occ;
    logic                      fifo_wp, fifo_rp;
    logic [NUM_BANKS*DW-1:0]   fifo_data [2];
    logic [1:0]                fifo_last;
    logic [NUM_BANKS*DW-1:0]   rd_word;
    logic                      clr_valid;
    logic [AW-1:0]             clr_addr;

    generate
        if (NUM_BANKS == (1 << BW)) begin : g_bank_full
            assign bank_bad = 1'b0;
        end else begin : g_bank_part
            assign bank_bad = ({1'b0, partial_bank} >= (BW+1)'(NUM_BANKS));
        end
    endgenerate

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = partial_valid && (state == ST_ACCUM) && !bank_bad;

    assign m_valid   = (fifo_cnt != 2'd0);
    assign m_data    = fifo_data[fifo_rp];
    assign m_last    = m_valid && fifo_last[fifo_rp];
    assign pop       = m_valid && m_ready;
    assign push      = rd_inflight;
    // Occupancy counts this cycle's pop so sustained ready streams one beat per cycle.
    assign occ       = fifo_cnt - {1'b0, pop} + {1'b0, rd_inflight};
    assign rd_issue  = (state == ST_DRAIN) && (cnt < len_q) && (occ < 2'd2);

    assign mem_re    = accept || rd_issue;
    assign mem_raddr = (state == ST_DRAIN) ? cnt[AW-1:0] : partial_addr;

    always_comb begin
        if (s2_valid && s2_bank == s1_bank && s2_addr == s1_addr)
            s1_old = s2_sum;
        else if (s3_valid && s3_bank == s1_bank && s3_addr == s1_addr)
            s1_old = s3_sum;
        else
            s1_old = rdata[s1_bank];
        sum_w  = (DW+1)'(s1_old) + (DW+1)'(s1_data);
        s1_res = SATURATE ? DW'(sat_clamp(32'(sum_w), DW)) : sum_w[DW-1:0];
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_word[b*DW +: DW] = rdata[b];
            mem_we[b]    = 1'b0;
            mem_waddr[b] = '0;
            mem_wdata[b] = '0;
            if (state == ST_FILL) begin
                mem_we[b]    = 1'b1;
                mem_waddr[b] = cnt[AW-1:0];
                mem_wdata[b] = bias_q[b*DW +: DW];
            end else if (clr_valid) begin
                mem_we[b]    = 1'b1;
                mem_waddr[b] = clr_addr;
            end else if (s2_valid && s2_bank == BW'(b)) begin
                mem_we[b]    = 1'b1;
                mem_waddr[b] = s2_addr;
                mem_wdata[b] = s2_sum;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        acc_bank_mem #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_mem (
            .clk   (clk),
            .we    (mem_we[b]),
            .waddr (mem_waddr[b]),
            .wdata (mem_wdata[b]),
            .re    (mem_re),
            .raddr (mem_raddr),
            .rdata (rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            len_q  <= '0;
            bias_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    cnt   <= '0;
                    len_q <= cmd_len;
                    case (cmd_op)
                        OP_FILL: begin
                            bias_q <= bias_vec;
                            state  <= ST_FILL;
                        end
                        OP_ACCUM: state <= ST_ACCUM;
                        OP_DRAIN: state <= ST_DRAIN;
                        default:  state <= ST_IDLE;
                    endcase
                end
                ST_FILL: begin
                    cnt <= cnt + (AW+1)'(1);
                    if (cnt + (AW+1)'(1) >= len_q) state <= ST_IDLE;
                end
                ST_ACCUM: if (accum_done) state <= ST_FLUSH;
                // S2 commits on the same edge S1 empties, so only S1 needs watching.
                ST_FLUSH: if (!s1_valid) state <= ST_IDLE;
                ST_DRAIN: begin
                    if (rd_issue) cnt <= cnt + (AW+1)'(1);
                    if (pop && m_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0;
            s1_bank <= '0; s2_bank <= '0; s3_bank <= '0;
            s1_addr <= '0; s2_addr <= '0; s3_addr <= '0;
            s1_data <= '0; s2_sum <= '0; s3_sum <= '0;
            err_drop <= 1'b0;
            rd_inflight <= 1'b0; rd_inflight_last <= 1'b0;
            fifo_cnt <= '0; fifo_wp <= 1'b0; fifo_rp <= 1'b0;
            fifo_data[0] <= '0; fifo_data[1] <= '0; fifo_last <= '0;
            clr_valid <= 1'b0; clr_addr <= '0;
        end else begin
            s1_valid <= accept;
            s1_bank  <= partial_bank;
            s1_addr  <= partial_addr;
            s1_data  <= partial_data;
            s2_valid <= s1_valid;
            s2_bank  <= s1_bank;
            s2_addr  <= s1_addr;
            s2_sum   <= s1_res;
            s3_valid <= s2_valid;
            s3_bank  <= s2_bank;
            s3_addr  <= s2_addr;
            s3_sum   <= s2_sum;
            if (partial_valid && (state != ST_ACCUM || bank_bad)) err_drop <= 1'b1;

            rd_inflight      <= rd_issue;
            rd_inflight_last <= rd_issue && (cnt == len_q - (AW+1)'(1));
            if (push) begin
                fifo_data[fifo_wp] <= rd_word;
                fifo_last[fifo_wp] <= rd_inflight_last;
                fifo_wp            <= ~fifo_wp;
            end
            if (pop) fifo_rp <= ~fifo_rp;
            fifo_cnt  <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            clr_valid <= CLEAR_ON_READ && rd_issue;
            clr_addr  <= cnt[AW-1:0];
        end
    end

endmodule

// File: tb/tb_accum_bank_array_v2.sv
// tb/tb_accum_bank_array_v2.sv - directed self-checking bench for accum_bank_array_v2
module tb_accum_bank_array_v2;
    import acc_bank_pkg::*;

    localparam int DW = 16, NB = 16, DEPTH = 512, AW = 9, BW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [AW:0]       cmd_len;
    logic              cmd_ready;
    logic [NB*DW-1:0]  bias_vec;
    logic              partial_valid;
    logic [DW-1:0]     partial_data;
    logic [BW-1:0]     partial_bank;
    logic [AW-1:0]     partial_addr;
    logic              accum_done;
    logic [NB*DW-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              err_drop;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NB*DW-1:0] beat_data [$];
    logic             beat_last [$];
    logic [NB*DW-1:0] bias;

    always #5 clk = ~clk;

    accum_bank_array_v2 #(
        .DW(DW), .NUM_BANKS(NB), .DEPTH(DEPTH), .AW(AW), .BW(BW),
        .SATURATE(1'b1), .CLEAR_ON_READ(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
        .bias_vec(bias_vec),
        .partial_valid(partial_valid), .partial_data(partial_data),
        .partial_bank(partial_bank), .partial_addr(partial_addr), .accum_done(accum_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .err_drop(err_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] fld(input logic [NB*DW-1:0] d, input int b);
        return d[b*DW +: DW];
    endfunction

    task automatic send_cmd(input logic [1:0] op, input int len);
        int n = 0;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = (AW+1)'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin tick(); n++; end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_fill(input int len, input logic [NB*DW-1:0] b);
        int n = 0;
        bias_vec = b;
        send_cmd(OP_FILL, len);
        while (busy && n < 1000) begin tick(); n++; end
        check("fill_cycles", 32'(n), 32'(len));
    endtask

    task automatic accum_ramp(input int n);
        send_cmd(OP_ACCUM, 0);
        for (int a = 0; a < n; a++) begin
            partial_valid = 1'b1;
            partial_bank  = '0;
            partial_addr  = AW'(a);
            partial_data  = DW'(a + 1);
            accum_done    = (a == n - 1);
            tick();
        end
        partial_valid = 1'b0;
        accum_done    = 1'b0;
        wait_idle();
    endtask

    task automatic drain_collect(input int len, input logic [3:0] pat);
        int i = 0;
        logic stalled = 1'b0;
        logic [NB*DW-1:0] held = '0;
        beat_data.delete();
        beat_last.delete();
        while (beat_data.size() < len && i < 500) begin
            if (stalled) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data == held), 32'd1);
            end
            m_ready = pat[i % 4];
            if (m_valid && m_ready) begin
                beat_data.push_back(m_data);
                beat_last.push_back(m_last);
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
            tick();
            i++;
        end
        m_ready = 1'b0;
        check("drain_beats", 32'(beat_data.size()), 32'(len));
        check("drain_busy_after", 32'(busy), 32'd0);
    endtask

    task automatic drain(input int len, input logic [3:0] pat);
        send_cmd(OP_DRAIN, len);
        drain_collect(len, pat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int k;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; bias_vec = '0;
        partial_valid = 1'b0; partial_data = '0; partial_bank = '0; partial_addr = '0;
        accum_done = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_err_drop", 32'(err_drop), 32'd0);
        check("rst_m_data_zero", 32'(m_data == '0), 32'd1);

        // Bias fill then full-rate drain
        bias = '0;
        bias[0*DW +: DW] = 16'd5;
        bias[3*DW +: DW] = 16'hFFFE;
        do_fill(4, bias);
        drain(4, 4'b1111);
        for (int i = 0; i < beat_data.size(); i++) begin
            check("t1_bank0", 32'(fld(beat_data[i], 0)), 32'h5);
            check("t1_bank3", 32'(fld(beat_data[i], 3)), 32'hFFFE);
            check("t1_last", 32'(beat_last[i]), 32'(i == 3));
        end

        // Back-to-back hits to one address
        do_fill(16, '0);
        send_cmd(OP_ACCUM, 0);
        partial_valid = 1'b1; partial_bank = 4'd2; partial_addr = 9'd7;
        partial_data = 16'd3; tick();
        partial_data = 16'd4; tick();
        partial_data = 16'd5; accum_done = 1'b1; tick();
        partial_valid = 1'b0; accum_done = 1'b0;
        wait_idle();
        drain(8, 4'b1111);
        if (beat_data.size() == 8) begin
            check("t2_fwd_sum", 32'(fld(beat_data[7], 2)), 32'd12);
            check("t2_other_addr", 32'(fld(beat_data[6], 2)), 32'd0);
        end

        // Saturation at both rails
        bias = '0;
        bias[0*DW +: DW] = 16'h7FF8;
        bias[1*DW +: DW] = 16'h8008;
        do_fill(1, bias);
        send_cmd(OP_ACCUM, 0);
        partial_valid = 1'b1; partial_addr = '0;
        partial_bank = 4'd0; partial_data = 16'd100; tick();
        partial_bank = 4'd1; partial_data = 16'hFF9C; accum_done = 1'b1; tick();
        partial_valid = 1'b0; accum_done = 1'b0;
        wait_idle();
        drain(1, 4'b1111);
        if (beat_data.size() == 1) begin
            check("t3_sat_pos", 32'(fld(beat_data[0], 0)), 32'h7FFF);
            check("t3_sat_neg", 32'(fld(beat_data[0], 1)), 32'h8000);
        end

        // Stalled drain in address order, then clear-on-read check
        do_fill(8, '0);
        accum_ramp(8);
        drain(8, 4'b1001);
        for (int i = 0; i < beat_data.size(); i++) begin
            check("t4_order", 32'(fld(beat_data[i], 0)), 32'(i + 1));
            check("t4_last", 32'(beat_last[i]), 32'(i == 7));
        end
        drain(8, 4'b1111);
        for (int i = 0; i < beat_data.size(); i++)
            check("t4_cleared", 32'(beat_data[i] != '0), 32'd0);
        check("t4_no_err", 32'(err_drop), 32'd0);

        // Reset in the middle of a drain
        do_fill(8, '0);
        accum_ramp(8);
        send_cmd(OP_DRAIN, 8);
        m_ready = 1'b1;
        got = 0; k = 0;
        while (got < 3 && k < 100) begin
            if (m_valid) got++;
            tick();
            k++;
        end
        check("t6_pre_beats", 32'(got), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ready = 1'b0;
        check("t6_m_valid", 32'(m_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        drain(8, 4'b1111);
        if (beat_data.size() == 8) begin
            check("t6_addr0", 32'(fld(beat_data[0], 0)), 32'd0);
            check("t6_addr6", 32'(fld(beat_data[6], 0)), 32'd7);
            check("t6_addr7", 32'(fld(beat_data[7], 0)), 32'd8);
            check("t6_last", 32'(beat_last[7]), 32'd1);
        end

        // Stray partial in IDLE and a command while busy
        bias = '0;
        bias[0*DW +: DW] = 16'd7;
        do_fill(1, bias);
        partial_valid = 1'b1; partial_bank = 4'd0; partial_addr = '0; partial_data = 16'd50;
        tick();
        partial_valid = 1'b0;
        check("t5_err_drop", 32'(err_drop), 32'd1);
        send_cmd(OP_DRAIN, 4);
        tick(); tick();
        bias = '0;
        bias[0*DW +: DW] = 16'd99;
        bias_vec  = bias;
        cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_len = 10'd4;
        check("t5_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick(); tick();
        cmd_valid = 1'b0;
        drain_collect(4, 4'b1111);
        if (beat_data.size() == 4) begin
            check("t5_mem_unchanged", 32'(fld(beat_data[0], 0)), 32'd7);
            for (int i = 1; i < 4; i++)
                check("t5_no_fill", 32'(fld(beat_data[i], 0)), 32'd0);
        end
        check("t5_err_sticky", 32'(err_drop), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
